// File: rtl/usb_kbd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_kbd_pkg: shared state encoding and report layout | rev 1.0          |
// +--------------------------------------------------------------------------+
package usb_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam int         REPORT_LEN = 8;
  localparam logic [2:0] MOD_IDX    = 3'd0;
  localparam logic [2:0] KEY_IDX    = 3'd2;
  localparam logic [2:0] LAST_IDX   = 3'(REPORT_LEN - 1);

endpackage
`default_nettype wire

// File: rtl/usb_kbd_key_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_kbd_key_fifo: sync FIFO with flush, full/empty and count | rev 1.0  |
// +--------------------------------------------------------------------------+
module usb_kbd_key_fifo
  import usb_kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage is deliberately left out of reset; empty-queue contents are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_kbd_report_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_kbd_report_sched: key events -> 8-byte press/release HID reports | 1.0|
// +--------------------------------------------------------------------------+
module usb_kbd_report_sched
  import usb_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usb_rstn,
  input  logic [15:0] key_value,
  input  logic        key_request,
  output logic        key_ready,
  output logic        key_overflow,
  output logic [7:0]  ep81_data,
  output logic        ep81_valid,
  input  logic        ep81_ready,
  output logic        busy
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    byte_cnt;
  logic [2:0]    byte_cnt_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_nxt;
  logic [15:0]   report;
  logic [15:0]   report_nxt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_rdata;
  logic          fifo_push;
  logic          fifo_pop;
  logic          xfer;

  assign key_ready    = ~fifo_full & usb_rstn;
  assign key_overflow = key_request & ~key_ready & usb_rstn;
  assign fifo_push    = key_request & key_ready;
  assign fifo_pop     = (state == ST_IDLE) & ~fifo_empty & usb_rstn;
  assign ep81_valid   = (state == ST_PRESS) | (state == ST_RELEASE);
  assign xfer         = ep81_valid & ep81_ready;
  assign busy         = (state != ST_IDLE) | (fifo_count != '0);

  usb_kbd_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (~usb_rstn),
    .push  (fifo_push),
    .wdata (key_value),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output byte depends only on registered state, so ep81_ready never reaches it.
  always_comb begin
    ep81_data = 8'h00;
    if (state == ST_PRESS) begin
      case (byte_cnt)
        MOD_IDX: ep81_data = report[15:8];
        KEY_IDX: ep81_data = report[7:0];
        default: ep81_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= 3'd0;
      gap_cnt  <= '0;
      report   <= 16'h0000;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      report   <= report_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    report_nxt   = report;
    if (!usb_rstn) begin
      // Link loss abandons any report in flight; it is never resumed.
      state_nxt    = ST_IDLE;
      byte_cnt_nxt = 3'd0;
      gap_cnt_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            report_nxt   = fifo_rdata;
            byte_cnt_nxt = 3'd0;
            state_nxt    = ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (xfer) begin
            byte_cnt_nxt = byte_cnt + 3'd1;
            if (byte_cnt == LAST_IDX) begin
              byte_cnt_nxt = 3'd0;
              state_nxt    = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (xfer) begin
            byte_cnt_nxt = byte_cnt + 3'd1;
            if (byte_cnt == LAST_IDX) begin
              byte_cnt_nxt = 3'd0;
              if (GAP_CYCLES == 0) begin
                state_nxt = ST_IDLE;
              end else begin
                state_nxt   = ST_GAP;
                gap_cnt_nxt = GAP_LOAD;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt - GW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_kbd_report_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_kbd_report_sched: directed + randomized checks vs report model    |
// +--------------------------------------------------------------------------+
module tb_usb_kbd_report_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        usb_rstn;
  logic [15:0] key_value;
  logic        key_request;
  logic        key_ready;
  logic        key_overflow;
  logic [7:0]  ep81_data;
  logic        ep81_valid;
  logic        ep81_ready;
  logic        busy;

  int total = 0;
  int bad = 0;
  int stall_viol = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  usb_kbd_report_sched #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .usb_rstn     (usb_rstn),
    .key_value    (key_value),
    .key_request  (key_request),
    .key_ready    (key_ready),
    .key_overflow (key_overflow),
    .ep81_data    (ep81_data),
    .ep81_valid   (ep81_valid),
    .ep81_ready   (ep81_ready),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    ep81_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       ep81_ready = 1'b0;
        1:       ep81_ready = 1'b1;
        2:       ep81_ready = ~ep81_ready;
        default: ep81_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Byte logger and stall-stability watcher, sampled mid-cycle.
  initial begin
    logic       pv, pr, pu;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pu = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && pu && !(ep81_valid && ep81_data === pd)) stall_viol++;
        if (ep81_valid && ep81_ready && usb_rstn) got_q.push_back(ep81_data);
        pv = ep81_valid; pr = ep81_ready; pu = usb_rstn; pd = ep81_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One report = press bytes (modifier, 0, usage, 0 x5) followed by 8 zero bytes.
  task automatic add_report(input logic [15:0] ev);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      exp_q.push_back(ev[15:8]);
      else if (i == 2) exp_q.push_back(ev[7:0]);
      else             exp_q.push_back(8'h00);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_step(input logic req, input logic [15:0] val);
    @(negedge clk);
    key_request = req;
    key_value   = val;
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      drive_step(1'b0, 16'h0);
      n++;
    end while (busy && n < budget);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] v, a, b, c;
    rst = 1'b1; usb_rstn = 1'b0; key_request = 1'b0; key_value = 16'h0;
    #1;
    check("rst_ready_linkdown", key_ready, 1'b0);
    check("rst_valid", ep81_valid, 1'b0);
    check("rst_data", ep81_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", key_overflow, 1'b0);
    usb_rstn = 1'b1;
    #1;
    check("rst_ready_linkup", key_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single event, ready tied high: exact cycle timing of valid and busy.
    got_q.delete(); exp_q.delete();
    add_report(16'h0204);
    drive_step(1'b1, 16'h0204);
    check("t1_ready", key_ready, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      drive_step(1'b0, 16'h0);
      check($sformatf("t1_valid_c%0d", i), ep81_valid, (i >= 2 && i <= 17));
      check($sformatf("t1_busy_c%0d", i), busy, (i <= 21));
    end
    check_stream("t1");

    // Ready toggling every cycle.
    ready_mode = 2;
    drive_step(1'b0, 16'h0);
    drive_step(1'b0, 16'h0);
    add_report(16'h001E);
    drive_step(1'b1, 16'h001E);
    wait_idle("t2", 300);
    check_stream("t2");
    check("t2_stall", stall_viol, 0);

    // Stalled link: primer occupies the FSM, then 6 requests into a 4-deep queue.
    ready_mode = 0;
    drive_step(1'b0, 16'h0);
    drive_step(1'b0, 16'h0);
    v = 16'($urandom);
    add_report(v);
    drive_step(1'b1, v);
    for (int i = 0; i < 4; i++) drive_step(1'b0, 16'h0);
    check("t3_stalled_valid", ep81_valid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      drive_step(1'b1, v);
      check($sformatf("t3_ready_r%0d", i), key_ready, (i < 4));
      check($sformatf("t3_ovf_r%0d", i), key_overflow, (i >= 4));
      if (i < 4) add_report(v);
    end
    drive_step(1'b0, 16'h0);
    check("t3_ready_full", key_ready, 1'b0);
    check("t3_ovf_quiet", key_overflow, 1'b0);
    ready_mode = 3;
    wait_idle("t3", 3000);
    check_stream("t3");
    check("t3_stall", stall_viol, 0);

    // Push on the exact IDLE->PRESS decision cycle.
    ready_mode = 1;
    drive_step(1'b0, 16'h0);
    drive_step(1'b0, 16'h0);
    a = 16'($urandom); b = 16'($urandom);
    add_report(a); add_report(b);
    drive_step(1'b1, a);
    drive_step(1'b1, b);
    check("t4_ready", key_ready, 1'b1);
    wait_idle("t4", 200);
    check_stream("t4");

    // Link loss while press byte 3 is presented, two events queued.
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    drive_step(1'b1, a);
    drive_step(1'b1, b);
    drive_step(1'b1, c);
    drive_step(1'b0, 16'h0);
    drive_step(1'b0, 16'h0);
    @(negedge clk);
    usb_rstn = 1'b0;
    #1;
    check("t5_b3_valid", ep81_valid, 1'b1);
    check("t5_b3_data", ep81_data, 8'h00);
    check("t5_ready_down", key_ready, 1'b0);
    drive_step(1'b1, 16'($urandom));
    check("t5_valid_off", ep81_valid, 1'b0);
    check("t5_busy_off", busy, 1'b0);
    check("t5_ready_blocked", key_ready, 1'b0);
    check("t5_ovf_blocked", key_overflow, 1'b0);
    @(negedge clk);
    key_request = 1'b0;
    usb_rstn = 1'b1;
    for (int i = 0; i < 30; i++) drive_step(1'b0, 16'h0);
    check("t5_quiet_busy", busy, 1'b0);
    add_report(a);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    check_stream("t5_partial");
    v = 16'($urandom);
    add_report(v);
    drive_step(1'b1, v);
    wait_idle("t5", 200);
    check_stream("t5_new");

    // Asynchronous reset in the middle of the release phase.
    v = 16'($urandom);
    drive_step(1'b1, v);
    for (int i = 1; i <= 13; i++) drive_step(1'b0, 16'h0);
    check("t6_mid_valid", ep81_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", ep81_valid, 1'b0);
    check("t6_data", ep81_data, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_ovf", key_overflow, 1'b0);
    check("t6_ready", key_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) drive_step(1'b0, 16'h0);
    check("t6_quiet_busy", busy, 1'b0);
    add_report(v);
    while (exp_q.size() > 12) void'(exp_q.pop_back());
    check_stream("t6");

    // Random events, random spacing, random ready.
    ready_mode = 3;
    for (int k = 0; k < 3; k++) begin
      v = 16'($urandom);
      add_report(v);
      drive_step(1'b1, v);
      for (int j = 0; j < int'($urandom_range(0, 40)); j++) drive_step(1'b0, 16'h0);
    end
    wait_idle("t7", 2000);
    check_stream("t7");
    check("t7_stall", stall_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
